// File: rtl/ninja_pkg.sv
// Shared types and constants for the NinjaReflex round sequencer.
package ninja_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_PROMPT = 3'd2,
        ST_RESULT = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    localparam logic [7:0] LFSR_SEED     = 8'h5A;
    // Fibonacci taps 8,6,5,4 expressed as a bit mask of the 8-bit register
    localparam logic [7:0] LFSR_TAPS     = 8'b1011_1000;
    localparam logic [2:0] MAX_WRONG_DEF = 3'd5;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], ^(x & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Game-tick prescaler: counts 0..TICK_DIV-1 and pulses tick on the wrap; clr restarts the count.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/reflex_round_ctrl.sv
// NinjaReflex round sequencer: random arm delay, prompt, reaction window, hit/miss scoring.
// Optional EARLY_PRESS_PENALTY_EN: a press while ARMED is scored as a miss.
module reflex_round_ctrl
    import ninja_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned DELAY_MIN    = 500,
    parameter int unsigned DELAY_SPAN   = 1024,
    parameter int unsigned WINDOW       = 400,
    parameter int unsigned RESULT_TICKS = 1000,
    parameter logic [2:0]  MAX_WRONG    = MAX_WRONG_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       switch,
    input  logic       btn,
    output logic       start,
    output logic       prompt,
    output logic       hit,
    output logic       miss,
    output logic [2:0] wrong_time,
    output logic [7:0] score,
    output logic [7:0] react_ticks,
    output logic       game_over
);

    localparam int         CW        = 16;
    localparam logic [7:0] SPAN_MASK = 8'(DELAY_SPAN - 1);

    state_t          state_q, state_d;
    logic            btn_q;
    logic [7:0]      lfsr_q;
    logic [CW-1:0]   delay_q;
    logic [CW-1:0]   tick_cnt_q;
    logic            tick;
    logic            press;
    logic            entry;
    logic            hit_d, miss_d;
    logic            start_q, prompt_q, hit_q, miss_q, over_q;
    logic [2:0]      wrong_q;
    logic [7:0]      score_q, react_q;

    assign press = btn & ~btn_q;
    assign entry = (state_d != state_q);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (entry),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (switch) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!switch) begin
                    state_d = ST_IDLE;
`ifdef EARLY_PRESS_PENALTY_EN
                // RESULT decides between re-arming and OVER once the miss is counted
                end else if (press) begin
                    miss_d  = 1'b1;
                    state_d = ST_RESULT;
`endif
                end else if (tick_cnt_q == delay_q) begin
                    state_d = ST_PROMPT;
                end
            end
            ST_PROMPT: begin
                if (!switch) begin
                    state_d = ST_IDLE;
                end else if (press) begin
                    hit_d   = 1'b1;
                    state_d = ST_RESULT;
                end else if (tick_cnt_q == CW'(WINDOW)) begin
                    miss_d  = 1'b1;
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (!switch) begin
                    state_d = ST_IDLE;
                end else if (tick_cnt_q == CW'(RESULT_TICKS)) begin
                    state_d = (wrong_q == MAX_WRONG) ? ST_OVER : ST_ARMED;
                end
            end
            ST_OVER: begin
                if (!switch) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            btn_q      <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            delay_q    <= '0;
            tick_cnt_q <= '0;
            start_q    <= 1'b0;
            prompt_q   <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            over_q     <= 1'b0;
            wrong_q    <= '0;
            score_q    <= '0;
            react_q    <= '0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn;
            lfsr_q  <= lfsr_next(lfsr_q);

            if (entry) begin
                tick_cnt_q <= '0;
            end else if (tick && (tick_cnt_q != '1)) begin
                tick_cnt_q <= tick_cnt_q + CW'(1);
            end

            if (entry && (state_d == ST_ARMED)) begin
                delay_q <= CW'(DELAY_MIN) + CW'(lfsr_q & SPAN_MASK);
            end

            if ((state_q == ST_IDLE) && (state_d == ST_ARMED)) begin
                wrong_q <= '0;
                score_q <= '0;
                react_q <= '0;
            end

            if (hit_d) begin
                if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                react_q <= (|tick_cnt_q[CW-1:8]) ? 8'hFF : tick_cnt_q[7:0];
            end

            if (miss_d && (wrong_q != MAX_WRONG)) begin
                wrong_q <= wrong_q + 3'd1;
            end

            start_q  <= entry && (state_d == ST_PROMPT);
            prompt_q <= (state_d == ST_PROMPT);
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            over_q   <= (state_d == ST_OVER);
        end
    end

    assign start       = start_q;
    assign prompt      = prompt_q;
    assign hit         = hit_q;
    assign miss        = miss_q;
    assign wrong_time  = wrong_q;
    assign score       = score_q;
    assign react_ticks = react_q;
    assign game_over   = over_q;

endmodule

// File: tb/tb_reflex_round_ctrl.sv
// Scoreboard bench for reflex_round_ctrl: expected start/hit/miss events are queued with their cycle.
module tb_reflex_round_ctrl;

    localparam int unsigned TD    = 4;
    localparam int unsigned DMIN  = 2;
    localparam int unsigned DSPAN = 4;
    localparam int unsigned WIN   = 8;
    localparam int unsigned RT    = 2;
    localparam logic [2:0]  MW    = 3'd3;

    localparam logic [2:0] K_START = 3'b100;
    localparam logic [2:0] K_HIT   = 3'b010;
    localparam logic [2:0] K_MISS  = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       switch = 1'b0;
    logic       btn = 1'b0;
    logic       start, prompt, hit, miss, game_over;
    logic [2:0] wrong_time;
    logic [7:0] score, react_ticks;

    reflex_round_ctrl #(
        .TICK_DIV     (TD),
        .DELAY_MIN    (DMIN),
        .DELAY_SPAN   (DSPAN),
        .WINDOW       (WIN),
        .RESULT_TICKS (RT),
        .MAX_WRONG    (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .switch      (switch),
        .btn         (btn),
        .start       (start),
        .prompt      (prompt),
        .hit         (hit),
        .miss        (miss),
        .wrong_time  (wrong_time),
        .score       (score),
        .react_ticks (react_ticks),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
        int         score;
        int         wrong;
        int         react;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] m_lfsr = 8'h5A;
    exp_t       mon_e;
    logic [2:0] mon_k;

    function automatic logic [7:0] lfsr_adv(input logic [7:0] x, input int n);
        logic [7:0] v;
        v = x;
        for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_lfsr <= rst ? 8'h5A : lfsr_adv(m_lfsr, 1);
    end

    always @(negedge clk) begin
        if (!rst && (start || hit || miss)) begin
            mon_k = {start, hit, miss};
            if (sb.size() == 0) begin
                check("unexpected_event", 32'(mon_k), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("event_kind", 32'(mon_k), 32'(mon_e.kind));
                check("event_cycle", cyc, mon_e.cyc);
                if (mon_e.kind == K_START) begin
                    check("prompt_with_start", 32'(prompt), 32'd1);
                end else begin
                    check("score", 32'(score), mon_e.score);
                    check("wrong_time", 32'(wrong_time), mon_e.wrong);
                    check("react_ticks", 32'(react_ticks), mon_e.react);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push(input logic [2:0] k, input int c, input int s, input int w, input int r);
        exp_t e;
        e.kind  = k;
        e.cyc   = c;
        e.score = s;
        e.wrong = w;
        e.react = r;
        sb.push_back(e);
    endtask

    // called on a falling edge: ARMED is entered on the next rising edge using the current LFSR
    task automatic arm_from_idle(output int s);
        int d;
        switch = 1'b1;
        d = int'(DMIN) + int'(m_lfsr & 8'(DSPAN - 1));
        s = cyc + int'(TD) * d + 2;
        push(K_START, s, 0, 0, 0);
    endtask

    // called on the falling edge where hit/miss is visible (RESULT just entered)
    task automatic next_round(input int r, output int s);
        int d;
        d = int'(DMIN) + int'(lfsr_adv(m_lfsr, int'(TD * RT)) & 8'(DSPAN - 1));
        s = r + int'(TD * RT) + 1 + int'(TD) * d + 1;
        push(K_START, s, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_start"}, 32'(start), 32'd0);
        check({pfx, "_prompt"}, 32'(prompt), 32'd0);
        check({pfx, "_hit"}, 32'(hit), 32'd0);
        check({pfx, "_miss"}, 32'(miss), 32'd0);
        check({pfx, "_wrong"}, 32'(wrong_time), 32'd0);
        check({pfx, "_score"}, 32'(score), 32'd0);
        check({pfx, "_react"}, 32'(react_ticks), 32'd0);
        check({pfx, "_over"}, 32'(game_over), 32'd0);
    endtask

    initial begin
        int s;
        int r;
        int exp_w;

        step(3);
        check_all_zero("reset");
        rst = 1'b0;
        step(3);
        check("idle_prompt", 32'(prompt), 32'd0);

        // hit three ticks after the prompt
        arm_from_idle(s);
        wait_until(s);
        check("prompt_up", 32'(prompt), 32'd1);
        wait_until(s + 3 * int'(TD));
        btn = 1'b1;
        r = s + 3 * int'(TD) + 1;
        push(K_HIT, r, 1, 0, 3);
        wait_until(r);
        check("prompt_drop_hit", 32'(prompt), 32'd0);
        next_round(r, s);
        step(1);
        btn = 1'b0;

        // three timeouts end the game
        for (int k = 1; k <= 3; k++) begin
            wait_until(s);
            r = s + int'(WIN * TD) + 1;
            push(K_MISS, r, 1, k, 3);
            wait_until(r);
            check("prompt_drop_miss", 32'(prompt), 32'd0);
            if (k < 3) next_round(r, s);
        end
        wait_until(r + int'(TD * RT));
        check("over_not_yet", 32'(game_over), 32'd0);
        step(1);
        check("game_over", 32'(game_over), 32'd1);
        check("over_wrong", 32'(wrong_time), 32'd3);
        check("over_score", 32'(score), 32'd1);
        step(5);
        check("over_holds", 32'(game_over), 32'd1);
        switch = 1'b0;
        step(1);
        check("over_to_idle", 32'(game_over), 32'd0);
        check("idle_score_held", 32'(score), 32'd1);
        check("idle_wrong_held", 32'(wrong_time), 32'd3);

        // press edge coinciding with window expiry is a hit
        step(2);
        arm_from_idle(s);
        step(1);
        check("rearm_clr_wrong", 32'(wrong_time), 32'd0);
        check("rearm_clr_score", 32'(score), 32'd0);
        check("rearm_clr_react", 32'(react_ticks), 32'd0);
        wait_until(s + int'(WIN * TD));
        btn = 1'b1;
        r = s + int'(WIN * TD) + 1;
        push(K_HIT, r, 1, 0, int'(WIN));
        wait_until(r);
        check("prompt_drop_edge", 32'(prompt), 32'd0);

        // press while ARMED
`ifndef EARLY_PRESS_PENALTY_EN
        next_round(r, s);
`endif
        step(1);
        btn = 1'b0;
        wait_until(r + int'(TD * RT) + 3);
        btn = 1'b1;
`ifdef EARLY_PRESS_PENALTY_EN
        push(K_MISS, r + int'(TD * RT) + 4, 1, 1, int'(WIN));
        wait_until(r + int'(TD * RT) + 4);
        check("early_wrong", 32'(wrong_time), 32'd1);
        next_round(r + int'(TD * RT) + 4, s);
        exp_w = 1;
`else
        step(1);
        check("early_ignored", 32'(wrong_time), 32'd0);
        exp_w = 0;
`endif

        // abort mid-PROMPT (button still held, so no press)
        wait_until(s);
        check("prompt_after_early", 32'(prompt), 32'd1);
        wait_until(s + 5);
        switch = 1'b0;
        step(1);
        check("abort_prompt", 32'(prompt), 32'd0);
        check("abort_score_held", 32'(score), 32'd1);
        check("abort_react_held", 32'(react_ticks), WIN);
        check("abort_wrong_held", 32'(wrong_time), exp_w);
        btn = 1'b0;

        // reset while ARMED after a hit
        step(2);
        arm_from_idle(s);
        wait_until(s + int'(TD));
        btn = 1'b1;
        r = s + int'(TD) + 1;
        push(K_HIT, r, 1, 0, 1);
        wait_until(r);
        step(1);
        btn = 1'b0;
        wait_until(r + int'(TD * RT) + 3);
        rst = 1'b1;
        switch = 1'b0;
        step(1);
        check_all_zero("midrst");
        rst = 1'b0;
        step(5);
        check("post_rst_idle", 32'(prompt), 32'd0);

        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reflex_round_ctrl.md
# reflex_round_ctrl

Round sequencer for the NinjaReflex reaction game. It waits a pseudo-random delay, lights the prompt, and times the player's button press against a reaction window. It then scores the round as a hit or a miss and accumulates `wrong_time` until the game ends. It sits between the debounced player inputs (`switch`, `btn`) and the display/counter logic, and issues the `start` pulse that launches each timed round.

## Interface
- `TICK_DIV`, default 50000: clk cycles per game tick.
- `DELAY_MIN`, default 500: minimum armed delay, in ticks.
- `DELAY_SPAN`, default 1024: random delay span, in ticks; must be a power of 2 and at most 256·k.
- `WINDOW`, default 400: reaction window length, in ticks.
- `RESULT_TICKS`, default 1000: hold time for the hit/miss display, in ticks.
- `MAX_WRONG`, default 3'd5: miss count that ends the game; range 1..7.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `switch` input 1: game enable level; already synchronized.
- `btn` input 1: player button; already synchronized and debounced.
- `start` output 1: one-cycle pulse on entry to PROMPT.
- `prompt` output 1: prompt lamp; high while in PROMPT.
- `hit` output 1: one-cycle pulse when a round is won.
- `miss` output 1: one-cycle pulse when a round is lost.
- `wrong_time` output 3: miss count; saturates at `MAX_WRONG`.
- `score` output 8: hit count; saturates at 255.
- `react_ticks` output 8: ticks from prompt to press, latched on hit; saturates at 255.
- `game_over` output 1: high while in OVER.

## Operation
- States:
  - IDLE
  - ARMED: random delay before the prompt.
  - PROMPT: reaction window open.
  - RESULT: hold after a hit or miss.
  - OVER: game ended.
- Press detection: `press = btn & ~btn_q`, where `btn_q` is registered. A held button produces no repeat presses.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Seed 8'h5A on `rst`; advances every cycle.
  - Sampled on each entry to ARMED: `delay = DELAY_MIN + (lfsr & (DELAY_SPAN-1))`, truncated to the LFSR width.
- Tick prescaler: counts 0..`TICK_DIV`-1 and emits `tick` on the wrap. It clears on every state entry, so the first tick arrives `TICK_DIV` cycles after entry.
- Tick counter: counts ticks since state entry and clears on state entry.
- Transitions:
  - IDLE→ARMED when `switch`=1. Clears `score`, `wrong_time` and `react_ticks`.
  - ARMED→PROMPT when the tick count reaches `delay`. Pulses `start`.
  - PROMPT→RESULT on `press`:
    - pulse `hit`;
    - `score`+1;
    - `react_ticks` = tick count.
  - PROMPT→RESULT when the tick count reaches `WINDOW` with no press:
    - pulse `miss`;
    - `wrong_time`+1.
  - A press in the same cycle as window expiry counts as a hit.
  - RESULT→ARMED after `RESULT_TICKS` ticks. If `wrong_time`==`MAX_WRONG`, go to OVER instead.
  - OVER→IDLE when `switch`=0.
  - Any state except OVER → IDLE when `switch`=0. `score`, `wrong_time` and `react_ticks` hold their values.
- Saturation: `wrong_time` and `score` never wrap. A miss at saturation leaves `wrong_time` unchanged.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE;
  - all outputs 0;
  - LFSR 8'h5A.
- `rst` mid-round takes priority over all transitions. The next cycle is IDLE with outputs 0.
- `start` and `prompt` rise in the same cycle. `prompt` falls in the cycle `hit` or `miss` pulses.
- `hit`, `miss`, `score` and `wrong_time` update in the cycle after the press edge or expiry tick.
- ARMED→PROMPT latency from ARMED entry: `delay`·`TICK_DIV` cycles, plus 1 for the registered output.

## Configuration
- `EARLY_PRESS_PENALTY_EN`:
  - Defined: a press in ARMED pulses `miss`, increments `wrong_time` and goes to RESULT (or OVER at `MAX_WRONG`).
  - Undefined: presses in ARMED are ignored.

## Structure
- Package `ninja_pkg`: state enum, LFSR seed and taps constant, `MAX_WRONG` default.
- One sub-module, `tick_gen`: prescaler with a synchronous clear input, outputting a `tick` pulse.
- FSM, LFSR and counters live in the top level.

## Test plan
Bench parameters: `TICK_DIV`=4, `DELAY_MIN`=2, `DELAY_SPAN`=4, `WINDOW`=8, `RESULT_TICKS`=2, `MAX_WRONG`=3.

- **Reset:** hold `rst` 3 cycles → all outputs 0, state IDLE.
- **Hit:** `switch`=1, then press 3 ticks after `start` → `hit` pulse, `score`=1, `react_ticks`=3, `prompt` drops.
- **Timeout:** no press → `miss` 8 ticks after `start`. After three rounds → `wrong_time`=3, `game_over`=1. `switch`=0 → IDLE.
- **Same-cycle press:** press edge on the window-expiry tick → `hit`, not `miss`.
- **Early press:** press during ARMED → with `EARLY_PRESS_PENALTY_EN`, `miss` and `wrong_time`=1; without it, no change.
- **Abort:** drop `switch` mid-PROMPT → IDLE next cycle, `score` held. Assert `rst` mid-ARMED → all outputs 0.
